spi_master: RTL and testbench

- Parametrised full-duplex SPI master; successor to the fixed 32-bit miso/mosi shift pair.
- Single block owns SCLK generation, chip-select, and simultaneous MOSI shift-out / MISO shift-in.
- Configurable word width, clock divider, CPOL/CPHA mode and multiple slave selects.
- Sits between the CPU load/store path (valid/ready handshake) and the external SPI pins.

---
 rtl/spi_master_pkg.sv | 29 ++
 rtl/spi_master_clkgen.sv | 59 +++++
 rtl/spi_master.sv | 152 +++++++++++++++
 tb/tb_spi_master.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_pkg.sv
// rtl/spi_master_pkg.sv - shared state encoding and mode constants for the SPI master
// Purpose: FSM state type, SPI mode constants {cpol, cpha}, default word width,
//          and the edge-counter width helper used by spi_master_clkgen.
// Ports:   none (package).
package spi_master_pkg;

    localparam int W_CPU = 32;

    typedef enum logic [1:0] {
        SPI_IDLE  = 2'd0,
        SPI_SETUP = 2'd1,
        SPI_XFER  = 2'd2,
        SPI_HOLD  = 2'd3
    } spi_state_t;

    // Mode constants encoded as {cpol, cpha}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    localparam bit DEBUG_SPI = 1'b0;

    // Edge counter must hold 2*W_Data without wrapping inside a word
    function automatic int edge_cnt_width(input int w_data);
        return $clog2(2 * w_data) + 1;
    endfunction

endpackage

// File: rtl/spi_master_clkgen.sv
// rtl/spi_master_clkgen.sv - half-period divider and SCLK edge counter
// Purpose: counts H = div+1 clk cycles per phase while the master is active and
//          numbers the SCLK edges of a word.
// Ports:   clk, rst (async active-low); run (any non-idle state); xfer (XFER state);
//          div (latched divider); tick (end of an H-cycle phase); edge_pulse (SCLK edge
//          in XFER); leading/trailing (kind of the pending edge); last_edge (edge 2*W_Data).
module spi_master_clkgen
    import spi_master_pkg::*;
#(
    parameter int W_Data = W_CPU,
    parameter int W_Div  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             xfer,
    input  logic [W_Div-1:0] div,
    output logic             tick,
    output logic             edge_pulse,
    output logic             leading,
    output logic             trailing,
    output logic             last_edge
);

    localparam int              W_Edge = edge_cnt_width(W_Data);
    localparam logic [W_Edge-1:0] LAST = W_Edge'(2 * W_Data - 1);

    logic [W_Div-1:0]  div_cnt;
    logic [W_Edge-1:0] edge_cnt;

    assign tick       = run && (div_cnt == div);
    assign edge_pulse = tick && xfer;
    // edge_cnt holds edges already made; the pending edge is number edge_cnt+1,
    // which is leading when odd, i.e. when edge_cnt is even
    assign leading    = !edge_cnt[0];
    assign trailing   = edge_cnt[0];
    assign last_edge  = (edge_cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (!run || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt <= '0;
        end else if (!xfer) begin
            edge_cnt <= '0;
        end else if (edge_pulse) begin
            edge_cnt <= edge_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - parametrised full-duplex SPI master
// Purpose: IDLE -> SETUP -> XFER -> HOLD word transfer with configurable width,
//          divider, CPOL/CPHA and chip select. Optional macro SPI_LOOPBACK_EN routes
//          the block's own mosi into the sampler instead of the miso pin.
// Ports:   clk, rst (async active-low); tx_data/tx_valid/tx_ready request handshake;
//          cs_sel, clk_div, cpol, cpha (latched at accept); rx_data/rx_valid result;
//          busy; sclk, mosi, miso, cs_n SPI pins.
module spi_master
    import spi_master_pkg::*;
#(
    parameter int W_Data = W_CPU,
    parameter int W_Div  = 8,
    parameter int N_CS   = 2,
    parameter int W_Sel  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W_Data-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [W_Sel-1:0]  cs_sel,
    input  logic [W_Div-1:0]  clk_div,
    input  logic              cpol,
    input  logic              cpha,
    output logic [W_Data-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [N_CS-1:0]   cs_n
);

    spi_state_t        state, state_nxt;
    logic              accept;
    logic [W_Sel-1:0]  cs_q;
    logic [W_Div-1:0]  div_q;
    logic              cpol_q, cpha_q, sclk_q, mosi_q;
    logic [W_Data-1:0] tx_sh, rx_sh;
    logic              tick, edge_pulse, leading, trailing, last_edge;
    logic              do_sample, do_shift, sample_in;

    assign accept = tx_valid && (state == SPI_IDLE);
    assign mosi   = mosi_q;

    spi_master_clkgen #(
        .W_Data (W_Data),
        .W_Div  (W_Div)
    ) u_clkgen (
        .clk        (clk),
        .rst        (rst),
        .run        (state != SPI_IDLE),
        .xfer       (state == SPI_XFER),
        .div        (div_q),
        .tick       (tick),
        .edge_pulse (edge_pulse),
        .leading    (leading),
        .trailing   (trailing),
        .last_edge  (last_edge)
    );

    // cpha=0: sample leading, advance mosi on trailing (the final trailing edge has no
    // next bit). cpha=1: drive on leading, sample trailing.
    assign do_sample = edge_pulse && (cpha_q ? trailing : leading);
    assign do_shift  = edge_pulse && (cpha_q ? leading : (trailing && !last_edge));

`ifdef SPI_LOOPBACK_EN
    logic unused_miso;
    assign unused_miso = miso;
    assign sample_in   = mosi_q;
`else
    assign sample_in   = miso;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= SPI_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SPI_IDLE:  if (accept)                  state_nxt = SPI_SETUP;
            SPI_SETUP: if (tick)                    state_nxt = SPI_XFER;
            SPI_XFER:  if (edge_pulse && last_edge) state_nxt = SPI_HOLD;
            SPI_HOLD:  if (tick)                    state_nxt = SPI_IDLE;
            default:                                state_nxt = SPI_IDLE;
        endcase
    end

    always_comb begin
        tx_ready = (state == SPI_IDLE);
        busy     = (state != SPI_IDLE);
        sclk     = (state == SPI_XFER) ? sclk_q : cpol_q;
        cs_n     = '1;
        // An out-of-range cs_q matches no index, so the frame runs with no slave selected
        for (int i = 0; i < N_CS; i++) begin
            cs_n[i] = !(busy && (cs_q == W_Sel'(i)));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs_q     <= '0;
            div_q    <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (state == SPI_IDLE) begin
                cpol_q <= cpol;
                if (accept) begin
                    cs_q   <= cs_sel;
                    div_q  <= clk_div;
                    cpha_q <= cpha;
                    sclk_q <= cpol;
                    if (!cpha) begin
                        // MSB must already be on the line before the first leading edge
                        mosi_q <= tx_data[W_Data-1];
                        tx_sh  <= tx_data << 1;
                    end else begin
                        tx_sh  <= tx_data;
                    end
                end
            end
            if (edge_pulse) begin
                sclk_q <= !sclk_q;
            end
            if (do_shift) begin
                mosi_q <= tx_sh[W_Data-1];
                tx_sh  <= tx_sh << 1;
            end
            if (do_sample) begin
                rx_sh <= {rx_sh[W_Data-2:0], sample_in};
            end
            if ((state == SPI_HOLD) && tick) begin
                rx_data  <= rx_sh;
                rx_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - self-checking bench for spi_master
module tb_spi_master;
    import spi_master_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [1:0] cs_sel = '0;
    logic [7:0] clk_div = '0;
    logic       cpol = 1'b0;
    logic       cpha = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       sclk;
    logic       mosi;
    logic       miso = 1'b0;
    logic [1:0] cs_n;

    logic [31:0] tx_data32 = '0;
    logic        tx_valid32 = 1'b0;
    logic        tx_ready32;
    logic        cs_sel32 = 1'b0;
    logic [7:0]  clk_div32 = '0;
    logic        cpol32 = 1'b0;
    logic        cpha32 = 1'b0;
    logic [31:0] rx_data32;
    logic        rx_valid32;
    logic        busy32;
    logic        sclk32;
    logic        mosi32;
    logic        miso32 = 1'b1;
    logic [1:0]  cs_n32;

    int n_cmp = 0;
    int n_bad = 0;

    // Slave / monitor state (written only by the monitor process)
    int         n_rxv = 0, cs_err = 0, int_err = 0;
    int         n_samp = 0, n_edges = 0, since = 0, sl_idx = 0;
    bit         sl_act = 0;
    logic       sl_prev = 1'b0;
    logic [7:0] sl_rx = '0;
    bit         lead;

    // Frame expectations (written only by the main process)
    logic       m_cpol = 1'b0, m_cpha = 1'b0;
    int         m_h = 1;
    logic [7:0] sl_byte = '0;
    logic [1:0] exp_cs = 2'b11;

    always #5 clk = ~clk;

    spi_master #(.W_Data(8), .W_Div(8), .N_CS(2), .W_Sel(2)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .cs_sel(cs_sel), .clk_div(clk_div), .cpol(cpol), .cpha(cpha),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
        .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
    );

    spi_master #(.W_Data(32), .W_Div(8), .N_CS(2), .W_Sel(1)) dut32 (
        .clk(clk), .rst(rst), .tx_data(tx_data32), .tx_valid(tx_valid32), .tx_ready(tx_ready32),
        .cs_sel(cs_sel32), .clk_div(clk_div32), .cpol(cpol32), .cpha(cpha32),
        .rx_data(rx_data32), .rx_valid(rx_valid32), .busy(busy32),
        .sclk(sclk32), .mosi(mosi32), .miso(miso32), .cs_n(cs_n32)
    );

    // Behavioural SPI slave and pin monitor, sampled on the falling clk edge
    always @(negedge clk) begin
        if (rx_valid) n_rxv++;
        if (busy) begin
            if (cs_n !== exp_cs) cs_err++;
        end else if (cs_n !== 2'b11) begin
            cs_err++;
        end
        if (!busy) begin
            sl_act = 0;
        end else if (!sl_act) begin
            sl_act  = 1;
            sl_prev = sclk;
            sl_rx   = '0;
            n_samp  = 0;
            n_edges = 0;
            since   = 0;
            sl_idx  = 7;
            if (!m_cpha) begin
                miso   = sl_byte[7];
                sl_idx = 6;
            end
        end else begin
            since++;
            if (sclk !== sl_prev) begin
                sl_prev = sclk;
                n_edges++;
                if (n_edges > 1 && since != m_h) int_err++;
                since = 0;
                lead  = (sclk !== m_cpol);
                if (lead == !m_cpha) begin
                    sl_rx = {sl_rx[6:0], mosi};
                    n_samp++;
                end else if (sl_idx >= 0) begin
                    miso = sl_byte[sl_idx];
                    sl_idx--;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rxv(input int n0, output int n);
        n = n0;
        while (rx_valid !== 1'b1 && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic check_frame(input string tag, input logic [7:0] d, input logic [7:0] sb, input int n);
        chk({tag, "_latency"}, n, 18 * m_h);
        chk({tag, "_rx_data"}, rx_data, sb);
        chk({tag, "_rxv_ready"}, tx_ready, 1);
        chk({tag, "_rxv_cs"}, cs_n, 2'b11);
        chk({tag, "_end_sclk"}, sclk, m_cpol);
        chk({tag, "_mosi_bits"}, sl_rx, d);
        chk({tag, "_n_samples"}, n_samp, 8);
        chk({tag, "_n_edges"}, n_edges, 16);
        chk({tag, "_cs_err"}, cs_err, 0);
        chk({tag, "_sclk_period"}, int_err, 0);
    endtask

    task automatic setup(input logic [7:0] d, input logic [7:0] sb, input logic [1:0] mode,
                         input logic [7:0] div, input logic [1:0] sel);
        m_cpol  = mode[1];
        m_cpha  = mode[0];
        m_h     = int'(div) + 1;
        sl_byte = sb;
        exp_cs  = (sel < 2'd2) ? ~(2'b01 << sel) : 2'b11;
        tx_data = d;
        cpol    = mode[1];
        cpha    = mode[0];
        clk_div = div;
        cs_sel  = sel;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_sclk", sclk, mode[1]);
        chk("idle_ready", tx_ready, 1);
    endtask

    task automatic xfer(input string tag, input logic [7:0] d, input logic [7:0] sb, input logic [1:0] mode,
                        input logic [7:0] div, input logic [1:0] sel, input bit scramble);
        int n, base;
        setup(d, sb, mode, div, sel);
        base = n_rxv;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        chk({tag, "_accept"}, busy, 1);
        if (scramble) begin
            tx_data = 8'($urandom);
            cpol    = 1'($urandom);
            cpha    = 1'($urandom);
            clk_div = 8'($urandom_range(0, 7));
            cs_sel  = 2'($urandom);
        end
        wait_rxv(0, n);
        check_frame(tag, d, sb, n);
        @(posedge clk); #1;
        chk({tag, "_pulse_once"}, n_rxv - base, 1);
        chk({tag, "_rxv_low"}, rx_valid, 0);
    endtask

    initial begin
        int n, base;
        logic [31:0] exp32;

        // Reset state, with cpol high to show sclk is forced low
        cpol = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", tx_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rxv", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_sclk", sclk, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_cs_n", cs_n, 2'b11);
        rst = 1'b1;

        // Mode 0..3 with the reference pattern
        xfer("m0", 8'hA5, 8'h3C, SPI_MODE0, 8'd1, 2'd0, 0);
        xfer("m1", 8'hA5, 8'h3C, SPI_MODE1, 8'd1, 2'd0, 0);
        xfer("m2", 8'hA5, 8'h3C, SPI_MODE2, 8'd1, 2'd0, 0);
        xfer("m3", 8'hA5, 8'h3C, SPI_MODE3, 8'd1, 2'd0, 0);

        // Back-to-back with tx_valid held high
        setup(8'h01, 8'h3C, SPI_MODE0, 8'd1, 2'd0);
        base = n_rxv;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_data = 8'hFF;
        chk("b2b_first_accept", busy, 1);
        wait_rxv(0, n);
        check_frame("b2b1", 8'h01, 8'h3C, n);
        @(posedge clk); #1;
        chk("b2b_second_accept", busy, 1);
        tx_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        wait_rxv(6, n);
        check_frame("b2b2", 8'hFF, 8'h3C, n);
        repeat (4) @(posedge clk);
        #1;
        chk("b2b_pulses", n_rxv - base, 2);
        chk("b2b_idle", busy, 0);

        // Asynchronous reset after 5 SCLK edges
        setup(8'hA5, 8'h3C, SPI_MODE0, 8'd1, 2'd0);
        base = n_rxv;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_sclk", sclk, 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_cs_n", cs_n, 2'b11);
        chk("mid_rst_sclk", sclk, 0);
        chk("mid_rst_ready", tx_ready, 1);
        chk("mid_rst_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("mid_rst_no_rxv", n_rxv - base, 0);
        xfer("post_rst", 8'h5A, 8'hC3, SPI_MODE0, 8'd1, 2'd0, 0);

        // Chip select targeting and out-of-range select, fastest divider
        xfer("cs1", 8'h96, 8'h69, SPI_MODE0, 8'd1, 2'd1, 0);
        xfer("cs3_div0", 8'h3C, 8'hA5, SPI_MODE0, 8'd0, 2'd3, 0);

        // Randomized transfers with inputs disturbed mid-transfer
        for (int i = 0; i < 16; i++) begin
            xfer("rnd", 8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)),
                 8'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1);
        end

        // 32-bit instance: loopback returns the sent word, otherwise miso is tied high
`ifdef SPI_LOOPBACK_EN
        exp32 = 32'hDEADBEEF;
`else
        exp32 = 32'hFFFFFFFF;
`endif
        tx_data32  = 32'hDEADBEEF;
        tx_valid32 = 1'b1;
        @(posedge clk); #1;
        tx_valid32 = 1'b0;
        chk("w32_accept", busy32, 1);
        n = 0;
        while (rx_valid32 !== 1'b1 && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("w32_latency", n, 66);
        chk("w32_rx_data", rx_data32, exp32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
